// File: rtl/mul8_nibble_seq_if.sv
// Operand/result handshake plus the shared 4x4 multiplier port of mul8_nibble_seq.
// The master side is the operand source, the result sink and the shared multiplier. The slave side is the sequencer.
interface mul8_nibble_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [3:0]  mul_m;
  logic [3:0]  mul_q;
  logic [7:0]  mul_p;

  modport master (
    output in_valid, a, b, acc_clr, out_ready, mul_p,
    input  in_ready, out_valid, product, busy, mul_m, mul_q
  );

  modport slave (
    input  in_valid, a, b, acc_clr, out_ready, mul_p,
    output in_ready, out_valid, product, busy, mul_m, mul_q
  );
endinterface

// File: rtl/mul8_nibble_seq.sv
// Computes an 8x8->16 unsigned product over four cycles using one external 4x4 multiplier.
// Defining MUL_SEQ_ACC_EN turns on multiply-accumulate mode, in which acc_clr selects whether an accept clears the accumulator.
module mul8_nibble_seq (
  input  logic              clk,
  input  logic              rst_n,
  mul8_nibble_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  step_reg, step_next;
  logic [7:0]  a_reg, a_next;
  logic [7:0]  b_reg, b_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] acc_start;
  logic [15:0] pp_shifted;
  logic [3:0]  mul_m, mul_q;
  logic [3:0]  a_nib [2];
  logic [3:0]  b_nib [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

`ifdef MUL_SEQ_ACC_EN
  assign acc_start = bus.acc_clr ? 16'h0000 : acc_reg;
`else
  assign acc_start = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= 2'd0;
      a_reg     <= 8'h00;
      b_reg     <= 8'h00;
      acc_reg   <= 16'h0000;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    mul_m      = 4'h0;
    mul_q      = 4'h0;
    pp_shifted = 16'h0000;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a;
          b_next     = bus.b;
          acc_next   = acc_start;
          step_next  = 2'd0;
          state_next = MUL;
        end
      end
      MUL: begin
        // step bit 0 picks the a nibble and step bit 1 picks the b nibble, so the shift is 4*(bit0+bit1)
        mul_m = a_nib[step_reg[0]];
        mul_q = b_nib[step_reg[1]];
        case (step_reg)
          2'd0:    pp_shifted = {8'h00, bus.mul_p};
          2'd3:    pp_shifted = {bus.mul_p, 8'h00};
          default: pp_shifted = {4'h0, bus.mul_p, 4'h0};
        endcase
        acc_next  = acc_reg + pp_shifted;
        step_next = step_reg + 2'd1;
        if (step_reg == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mul_m     = mul_m;
  assign bus.mul_q     = mul_q;
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg == MUL) || (state_reg == DONE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.product   = acc_reg;

endmodule
